f1_start_sequencer: RTL
=======================

// Module: f1_start_sequencer
// PURPOSE
//   Upstream driver for the F1 start-light FSM: generates that FSM's 1-cycle `en` strobes.
//   On a start-button press it issues 8 strobes spaced TICK_CYCLES apart (lights fill S0->S8).
//   It then holds for a pseudo-random number of ticks and issues a 9th strobe (lights out, S8->S0).
//   It also flags the lights-out instant for the downstream reaction timer.
// PARAMETERS
//   TICK_CYCLES  48  clk cycles per light step; legal range >= 2
//   LFSR_W       7   LFSR width; hold delay range 1..2^LFSR_W-1 ticks; only 7 supported
//   FIXED_DELAY  3   hold delay in ticks, used only when F1_SEQ_FIXED_DELAY_EN is defined; 1..2^LFSR_W-1
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   trigger      in   1       start button, level, synchronous to clk
//   en           out  1       1-cycle strobe to the light FSM's en input
//   lights_out   out  1       1-cycle pulse, coincident with the 9th en strobe
//   busy         out  1       high from the cycle after the accepted trigger through the lights-out cycle
//   delay_ticks  out  LFSR_W  hold delay captured for the current/last run
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; tick_cnt=0; step_cnt=0; hold_cnt=0; trig_q=0; lfsr=7'h01.
//   LFSR:
//     - Fibonacci, x^7+x^6+1: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
//     - Advances every cycle in every state, so press timing randomises the delay.
//     - Never reaches 0.
//   Trigger: trig_q <= trigger each cycle; start = trigger & ~trig_q (rising edge).
//     A held trigger never restarts a run; start is ignored unless state==IDLE.
//   States:
//     IDLE -> RAMP : on start. tick_cnt<=0, step_cnt<=0.
//     RAMP -> HOLD : on the 8th strobe.
//     HOLD -> IDLE : on the lights-out strobe.
//   Tick: while state!=IDLE, tick_cnt counts 0..TICK_CYCLES-1 and wraps.
//     tick = (tick_cnt==TICK_CYCLES-1).
//   RAMP:
//     - en=1 on each tick; step_cnt++.
//     - On the tick where step_cnt==7 (8th strobe): capture D=lfsr into delay_ticks,
//       hold_cnt<=D, go HOLD.
//   HOLD:
//     - On each tick, hold_cnt--.
//     - On the tick where hold_cnt==1: en=1, lights_out=1, next state IDLE.
//   Timing (start sampled at edge t):
//     - k-th ramp en (k=1..8) at cycle t+k*TICK_CYCLES.
//     - lights-out en at t+(8+D)*TICK_CYCLES.
//   busy = (state!=IDLE), registered. It drops the cycle after lights_out.
//   en and lights_out are registered outputs; never high for 2 consecutive cycles.
//   Exactly 9 en strobes per uninterrupted run.
//   delay_ticks holds its value until the next capture; 0 only after reset.
//   rst mid-run: next edge returns IDLE, no further en pulses. Downstream FSM shares rst, so it also restarts at S0.
//   rst and start in the same cycle: rst wins.
// CONFIGURATION
//   F1_SEQ_FIXED_DELAY_EN defined:
//     - Captured D = FIXED_DELAY instead of lfsr, for deterministic sims and demos.
//     - LFSR still runs, but its output is unused.
//   F1_SEQ_FIXED_DELAY_EN undefined: D = lfsr value (1..127).
// TESTING (TICK_CYCLES=4, F1_SEQ_FIXED_DELAY_EN defined with FIXED_DELAY=3 unless noted)
//   1. Reset then trigger rising at cycle 10 -> en at 14,18,22,26,30,34,38,42; en+lights_out at 54; busy 11..54.
//   2. Trigger held high 200 cycles -> exactly one run (9 en); no restart after busy drops until trigger toggles low->high.
//   3. Trigger pulses at cycles 20 and 30 during a run started at 10 -> ignored; strobe timing identical to scenario 1.
//   4. rst asserted at cycle 25 of scenario 1 -> from cycle 26: en=0, busy=0, delay_ticks=0; fresh trigger restarts at full timing.
//   5. Macro undefined: 20 runs -> delay_ticks in 1..127 each run; lights-out spacing = (8+delay_ticks)*4 cycles after start.
//   6. LFSR from reset (macro undefined, probed internally): period exactly 127; value 0 never seen; first values 01,02,04,08.

Source files
------------

// File: rtl/f1_start_sequencer.sv
// Start-light sequencer: 8 ramp strobes TICK_CYCLES apart, a random hold, then a lights-out strobe.
// Define F1_SEQ_FIXED_DELAY_EN to replace the LFSR hold delay with FIXED_DELAY.
module f1_start_sequencer #(
    parameter int TICK_CYCLES = 48,
    parameter int LFSR_W      = 7,
    parameter int FIXED_DELAY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    output logic              en,
    output logic              lights_out,
    output logic              busy,
    output logic [LFSR_W-1:0] delay_ticks
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     tick_cnt_q;
    logic [2:0]        step_cnt_q;
    logic [LFSR_W-1:0] hold_cnt_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] delay_q;
    logic [LFSR_W-1:0] cap_d;
    logic              trig_q;
    logic              en_q;
    logic              lights_out_q;
    logic              busy_q;
    logic              start;
    logic              tick;

    // x^7+x^6+1 free-running LFSR; press timing picks the hold delay.
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
    assign start  = trigger & ~trig_q;
    assign tick   = (tick_cnt_q == TW'(TICK_CYCLES - 1));

`ifdef F1_SEQ_FIXED_DELAY_EN
    assign cap_d = LFSR_W'(FIXED_DELAY);
`else
    assign cap_d = lfsr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            step_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            lfsr_q       <= LFSR_W'(1);
            delay_q      <= '0;
            trig_q       <= 1'b0;
            en_q         <= 1'b0;
            lights_out_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            trig_q       <= trigger;
            lfsr_q       <= lfsr_d;
            en_q         <= 1'b0;
            lights_out_q <= 1'b0;
            busy_q       <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RAMP;
                        tick_cnt_q <= '0;
                        step_cnt_q <= '0;
                    end
                end
                RAMP: begin
                    tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
                    if (tick) begin
                        en_q       <= 1'b1;
                        step_cnt_q <= step_cnt_q + 3'd1;
                        if (step_cnt_q == 3'd7) begin
                            delay_q    <= cap_d;
                            hold_cnt_q <= cap_d;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
                    if (tick) begin
                        hold_cnt_q <= hold_cnt_q - LFSR_W'(1);
                        if (hold_cnt_q == LFSR_W'(1)) begin
                            en_q         <= 1'b1;
                            lights_out_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en          = en_q;
    assign lights_out  = lights_out_q;
    assign busy        = busy_q;
    assign delay_ticks = delay_q;

endmodule
